i2c_shift_register_param: RTL and testbench

//  Parametrised serial shifter for the I2C master datapath: loads a parallel word, shifts it out/in on
//  a selectable edge of the (asynchronous) ShiftCLK line, counts bits and flags completion. Sits between
//  the I2C control FSM (Load/Start/Done) and the SDA/SCL pin logic; synchronises and edge-detects SCL itself.

---
 rtl/i2c_shift_register_param.sv | 134 +++++++++++++
 tb/tb_i2c_shift_register_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_shift_register_param.sv
// Parametrised I2C serial shifter: parallel load, SCL-synchronised shift, bit count and done pulse.
// Optional ACK phase (extra AckOut port, ACK state) enabled by defining I2C_SR_ACK_EN.
module i2c_shift_register_param #(
  parameter int unsigned      WIDTH      = 8,
  parameter bit               MSB_FIRST  = 1'b1,
  parameter bit               SHIFT_EDGE = 1'b0,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [WIDTH-1:0]             DataIn,
  input  logic                         Load,
  input  logic                         Start,
  input  logic                         ShiftCLK,
  input  logic                         ShiftIn,
  output logic [WIDTH-1:0]             DataOut,
  output logic                         ShiftOut,
  output logic                         Busy,
  output logic                         Done,
`ifdef I2C_SR_ACK_EN
  output logic                         AckOut,
`endif
  output logic [$clog2(WIDTH+1)-1:0]   BitCount
);

  localparam int unsigned CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ACK,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             scl_meta_q;
  logic             scl_sync_q;
  logic             scl_hist_q;
`ifdef I2C_SR_ACK_EN
  logic             ack_q;
`endif

  logic             strobe;
  logic [WIDTH-1:0] shifted;

  // Edge seen between the second sync stage and the history flop: the register
  // therefore moves on the third CLK edge after an SCL transition.
  always_comb begin
    strobe = SHIFT_EDGE ? (scl_sync_q & ~scl_hist_q) : (~scl_sync_q & scl_hist_q);
  end

  always_comb begin
    shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], ShiftIn} : {ShiftIn, sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      sr_q       <= INIT_VALUE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      scl_meta_q <= 1'b0;
      scl_sync_q <= 1'b0;
      scl_hist_q <= 1'b0;
`ifdef I2C_SR_ACK_EN
      ack_q      <= 1'b1;
`endif
    end else begin
      scl_meta_q <= ShiftCLK;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Load) sr_q <= DataIn;
          if (Start) begin
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
`ifdef I2C_SR_ACK_EN
            ack_q   <= 1'b1;
`endif
          end
        end
        ST_SHIFT: begin
          if (strobe) begin
            sr_q  <= shifted;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef I2C_SR_ACK_EN
              state_q <= ST_ACK;
`else
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end
          end
        end
`ifdef I2C_SR_ACK_EN
        ST_ACK: begin
          if (strobe) begin
            ack_q   <= ShiftIn;
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign DataOut  = sr_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign BitCount = cnt_q;

`ifdef I2C_SR_ACK_EN
  assign AckOut   = ack_q;
  // SDA is released while the slave drives the acknowledge bit.
  assign ShiftOut = (state_q == ST_ACK) ? 1'b1 : (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);
`else
  assign ShiftOut = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
`endif

endmodule

// File: tb/tb_i2c_shift_register_param.sv
// Directed bench for i2c_shift_register_param: an 8-bit MSB-first and a 4-bit LSB-first instance.
module tb_i2c_shift_register_param;

`ifdef I2C_SR_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, scl, sin;
  logic [7:0] din, dout;
  logic       load, start, so, busy, done;
  logic [3:0] cnt;
  logic [3:0] din2, dout2;
  logic       load2, start2, so2, busy2, done2;
  logic [2:0] cnt2;
`ifdef I2C_SR_ACK_EN
  logic       ack, ack2;
`endif

  i2c_shift_register_param #(.WIDTH(8), .MSB_FIRST(1'b1), .SHIFT_EDGE(1'b0)) u_dut8 (
    .CLK(clk), .RESET_N(rst_n), .DataIn(din), .Load(load), .Start(start),
    .ShiftCLK(scl), .ShiftIn(sin), .DataOut(dout), .ShiftOut(so), .Busy(busy),
    .Done(done),
`ifdef I2C_SR_ACK_EN
    .AckOut(ack),
`endif
    .BitCount(cnt)
  );

  i2c_shift_register_param #(.WIDTH(4), .MSB_FIRST(1'b0), .SHIFT_EDGE(1'b0)) u_dut4 (
    .CLK(clk), .RESET_N(rst_n), .DataIn(din2), .Load(load2), .Start(start2),
    .ShiftCLK(scl), .ShiftIn(sin), .DataOut(dout2), .ShiftOut(so2), .Busy(busy2),
    .Done(done2),
`ifdef I2C_SR_ACK_EN
    .AckOut(ack2),
`endif
    .BitCount(cnt2)
  );

  typedef struct {
    logic       sin;
    logic       exp_so;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t v8[8];
  vec_t v4[4];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scl_pulse(input logic s);
    sin = s;
    scl = 1'b0;
    repeat (3) tick();
    scl = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    logic [7:0] prev;
    logic       exp_done;

    v8[0] = '{1'b1, 1'b1, 8'h4B};
    v8[1] = '{1'b0, 1'b0, 8'h96};
    v8[2] = '{1'b1, 1'b1, 8'h2D};
    v8[3] = '{1'b1, 1'b0, 8'h5B};
    v8[4] = '{1'b0, 1'b0, 8'hB6};
    v8[5] = '{1'b0, 1'b1, 8'h6C};
    v8[6] = '{1'b1, 1'b0, 8'hD9};
    v8[7] = '{1'b0, 1'b1, 8'hB2};
    v4[0] = '{1'b0, 1'b1, 8'h4};
    v4[1] = '{1'b0, 1'b0, 8'h2};
    v4[2] = '{1'b0, 1'b0, 8'h1};
    v4[3] = '{1'b0, 1'b1, 8'h0};

    rst_n = 1'b0; scl = 1'b1; sin = 1'b0;
    din = '0; load = 1'b0; start = 1'b0;
    din2 = '0; load2 = 1'b0; start2 = 1'b0;
    repeat (2) tick();
    chk("reset_dout", dout, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_cnt", cnt, 4'd0);
    chk("reset_dout2", dout2, 4'h0);
    rst_n = 1'b1;
    repeat (4) tick();

    din = 8'hA5; load = 1'b1; tick(); load = 1'b0;
    chk("load_dout", dout, 8'hA5);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_cnt", cnt, 4'd0);

    for (int i = 0; i < 8; i++) begin
      prev = (i == 0) ? 8'hA5 : v8[i-1].exp_dout;
      chk($sformatf("so8[%0d]", i), so, v8[i].exp_so);
      sin = v8[i].sin;
      scl = 1'b0;
      repeat (2) tick();
      chk($sformatf("latency8[%0d]", i), dout, prev);
      tick();
      exp_done = (i == 7) && !ACK_EN;
      chk($sformatf("dout8[%0d]", i), dout, v8[i].exp_dout);
      chk($sformatf("cnt8[%0d]", i), cnt, i + 1);
      chk($sformatf("done8[%0d]", i), done, exp_done);
      chk($sformatf("busy8[%0d]", i), busy, !exp_done);
      scl = 1'b1;
      repeat (3) tick();
      chk($sformatf("rise8[%0d]", i), dout, v8[i].exp_dout);
      chk($sformatf("donepulse8[%0d]", i), done, 1'b0);
    end

`ifdef I2C_SR_ACK_EN
    chk("ack_busy", busy, 1'b1);
    chk("ack_so_released", so, 1'b1);
    chk("ack_pre", ack, 1'b1);
    sin = 1'b0; scl = 1'b0;
    repeat (3) tick();
    chk("ack_sampled", ack, 1'b0);
    chk("ack_done", done, 1'b1);
    chk("ack_busy_fall", busy, 1'b0);
    chk("ack_dout_hold", dout, 8'hB2);
    scl = 1'b1;
    repeat (3) tick();
`endif

    scl_pulse(1'b1);
    chk("idle_strobe_dout", dout, 8'hB2);
    chk("idle_cnt_held", cnt, 4'd8);

    start = 1'b1; tick(); start = 1'b0;
    chk("restart_cnt", cnt, 4'd0);
    din = 8'hFF; load = 1'b1; start = 1'b1;
    repeat (2) tick();
    load = 1'b0; start = 1'b0;
    chk("busy_load_ignored", dout, 8'hB2);
    chk("busy_start_ignored", cnt, 4'd0);
    for (int i = 0; i < 3; i++) scl_pulse(1'b1);
    chk("mid_dout", dout, 8'h97);
    chk("mid_cnt", cnt, 4'd3);

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dout", dout, 8'h00);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_cnt", cnt, 4'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    din2 = 4'h9; load2 = 1'b1; start2 = 1'b1; tick();
    load2 = 1'b0; start2 = 1'b0;
    chk("ls_dout2", dout2, 4'h9);
    chk("ls_busy2", busy2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("so4[%0d]", i), so2, v4[i].exp_so);
      sin = v4[i].sin;
      scl = 1'b0;
      repeat (3) tick();
      exp_done = (i == 3) && !ACK_EN;
      chk($sformatf("dout4[%0d]", i), dout2, v4[i].exp_dout[3:0]);
      chk($sformatf("cnt4[%0d]", i), cnt2, i + 1);
      chk($sformatf("done4[%0d]", i), done2, exp_done);
      scl = 1'b1;
      repeat (3) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
